// File: rtl/ieee754_seq_subtractor.sv
// Multi-cycle IEEE754 single-precision subtractor: result = a - b.
// Operands are aligned, added and normalised in separate states. Normalisation
// moves one bit per cycle. Rounding is by truncation only, and special values
// are handled as ordinary encodings.
module ieee754_seq_subtractor #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;         // minuend
  logic [31:0] bn_q, bn_d;       // subtrahend with its sign flipped
  logic        xs_q, xs_d;       // sign of the larger-magnitude operand
  logic [7:0]  xe_q, xe_d;       // exponent of the larger-magnitude operand
  logic [23:0] xm_q, xm_d;       // larger mantissa, with the implicit 1
  logic [23:0] ym_q, ym_d;       // smaller mantissa after alignment
  logic        sub_q, sub_d;     // signs differ, so this is an effective subtract
  logic [23:0] mant_q, mant_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [4:0]  cnt_q, cnt_d;     // normalisation shift count
  logic [31:0] res_q, res_d;
  logic        ov_q, ov_d;

  // Alignment: pick the larger magnitude (a wins a tie), then shift the other mantissa
  logic        a_ge;
  logic [31:0] x_op, y_op;
  logic [7:0]  diff;
  logic [23:0] ym_full, ym_sh;
  logic [24:0] sum;

  always_comb begin
    a_ge    = a_q[30:0] >= bn_q[30:0];
    x_op    = a_ge ? a_q : bn_q;
    y_op    = a_ge ? bn_q : a_q;
    diff    = x_op[30:23] - y_op[30:23];
    ym_full = {1'b1, y_op[22:0]};
    ym_sh   = (diff >= 8'd24) ? 24'h0 : (ym_full >> diff);
    sum     = sub_q ? ({1'b0, xm_q} - {1'b0, ym_q}) : ({1'b0, xm_q} + {1'b0, ym_q});
  end

  // State and datapath registers; rst aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      bn_q    <= '0;
      xs_q    <= 1'b0;
      xe_q    <= '0;
      xm_q    <= '0;
      ym_q    <= '0;
      sub_q   <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bn_q    <= bn_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      sub_q   <= sub_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state and datapath update for each FSM state
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bn_d    = bn_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    sub_d   = sub_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          bn_d    = {~b[31], b[30:0]};
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        xs_d    = x_op[31];
        xe_d    = x_op[30:23];
        xm_d    = {1'b1, x_op[22:0]};
        ym_d    = ym_sh;
        sub_d   = x_op[31] ^ y_op[31];
        state_d = ADD;
      end
      ADD: begin
        sign_d = xs_q;
        cnt_d  = '0;
        if (sum == 25'h0) begin
          res_d   = '0;
          state_d = DONE;
        end else if (sum[24]) begin
          mant_d  = sum[24:1];
          exp_d   = (xe_q == 8'hFF) ? 8'hFF : xe_q + 8'd1;
          state_d = NORM;
        end else begin
          mant_d  = sum[23:0];
          exp_d   = xe_q;
          state_d = NORM;
        end
      end
      NORM: begin
        if (!mant_q[23] && exp_q != 8'h0 && cnt_q < 5'd24) begin
          mant_d = {mant_q[22:0], 1'b0};
          exp_d  = exp_q - 8'd1;
          cnt_d  = cnt_q + 5'd1;
        end else begin
          res_d   = {sign_q, exp_q, mant_q[22:0]};
          ov_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // The zero shortcut arrives here one cycle early, so out_valid is raised
        // one cycle later. This keeps the latency at 3 + k.
        if (!ov_q) begin
          ov_d = 1'b1;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign result    = res_q;

endmodule

// File: doc/ieee754_seq_subtractor.md
Name: ieee754_seq_subtractor

Overview:
Multi-cycle IEEE754 single-precision subtractor computing result = A - B. It is the inverse-operation companion to the team's combinational IEEE754 adder and follows the same number semantics: implicit leading 1, truncation, no special-value handling. It is sequential and handshaked: alignment, add/subtract and normalisation run in separate states, with one normalisation shift per cycle. This shortens the critical path for the SVR datapath.

Parameters:
XLEN, 32, operand/result width; only 32 is supported (1 sign, 8 exponent, 23 mantissa bits).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operands a/b valid.
in_ready  output  1  block can accept operands.
a  input  XLEN  minuend, IEEE754 single.
b  input  XLEN  subtrahend, IEEE754 single.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  XLEN  a - b, IEEE754 single.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=32'h0, all internal registers 0. Asserting rst in any state aborts the operation immediately; no partial result is emitted.
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready=1; in_ready=0 in all other states.
  - Handshake edge (in_valid&&in_ready): latch a, and b with its sign bit inverted (b_neg); go to ALIGN.
- ALIGN:
  - Compare |a| and |b_neg| on bits [30:0]; the larger (ties: a) is X, the other is Y.
  - diff = X.exp - Y.exp (8-bit unsigned).
  - Y mantissa {1,m} is shifted right by diff; diff >= 24 gives 0. Truncate, no sticky/round bits.
  - Go to ADD.
- ADD:
  - Same signs: 25-bit sum. Different signs: X.mant - Ymant_shifted.
  - Carry set: mantissa >>1; exponent+1, saturating at 8'hFF.
  - Difference == 0: result=32'h0 (+0, all fields zero); go to DONE.
  - Otherwise: sign=X.sign, exponent=X.exp; go to NORM.
- NORM:
  - Each cycle, if mant[23]==0 AND exponent>0 AND shift count<24: mant<<=1, exponent-=1, count+=1.
  - Otherwise: result={sign, exponent, mant[22:0]}; go to DONE.
  - Shift counter is 5 bits and is cleared on entry to NORM.
- DONE:
  - out_valid=1. result is held stable while out_ready=0 (no limit on stall length).
  - On out_valid&&out_ready: out_valid=0 and go to IDLE. The next operand is accepted no earlier than the following cycle (no same-cycle overlap).
- Latency, counted from the acceptance edge E0: out_valid rises after edge E3+k, where k = number of normalisation shifts (0..24). Zero result: out_valid rises after E3 (ADD goes straight to DONE; DONE is entered on E2 and visible after E3 per the registered output). The implementation registers out_valid on entry to DONE, giving a fixed 3+k, with the zero result reporting k=0.
- Out-of-scope inputs: NaN, Inf and denormals are treated as ordinary normalised encodings. Exponent underflow stops at 0 with an unnormalised mantissa; overflow saturates the exponent at 8'hFF with a truncated mantissa.
- in_valid asserted outside IDLE is ignored. The a/b inputs are sampled only on the handshake edge.

Test Plan:
- a=32'h40400000 (3.0), b=32'h3F800000 (1.0) -> result=32'h40000000; k=0, out_valid after E3.
- a=32'h3F800000, b=32'hBF800000 (1.0 - -1.0), effective add with carry -> result=32'h40000000, exponent incremented, k=0.
- a=32'h3F800000, b=32'h3F400000 (1.0 - 0.75) -> result=32'h3E800000; k=2, out_valid after E5.
- a=32'h40000000, b=32'h40400000 (2.0 - 3.0), swap path -> result=32'hBF800000, k=1. Also a=b=32'h3F800000 -> result=32'h00000000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and result constant; in_ready=0 throughout and a new in_valid is ignored. On release, a one-cycle handshake occurs, then in_ready=1.
- Reset mid-NORM (1.0 - 0.75, rst asserted after E3 and held 1 cycle) -> immediately out_valid=0, in_ready=1, result=32'h0. A subsequent 3.0 - 1.0 gives 32'h40000000.
